// File: rtl/death_screen_sequencer.sv
// ---------------------------------------------------------------------------
// death_screen_sequencer
//
// Sits between the game renderer, the death-screen renderer and the OLED
// driver (96x64, RGB565). When the player dies, it fades the death screen in,
// holds it at full brightness, and waits for a button press once the hold has
// lasted long enough. It then fades back out and pulses a restart to the game.
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   pixel_index  current OLED pixel index (held for many clk cycles per pixel)
//   game_data    RGB565 pixel from the game renderer
//   death_data   RGB565 pixel from the death-screen renderer
//   player_dead  level, high while the game reports the player dead
//   btn_c        debounced single-cycle button pulse
//   oled_data    registered RGB565 pixel to the OLED driver
//   restart      one-cycle pulse when the fade-out completes
//   seq_state    current state: 0 PLAY, 1 FADE_IN, 2 HOLD, 3 FADE_OUT
// ---------------------------------------------------------------------------
module death_screen_sequencer #(
  parameter int SCREEN_PIXELS = 6144,
  parameter int FADE_FRAMES   = 4,
  parameter int HOLD_FRAMES   = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic [15:0] game_data,
  input  logic [15:0] death_data,
  input  logic        player_dead,
  input  logic        btn_c,
  output logic [15:0] oled_data,
  output logic        restart,
  output logic [1:0]  seq_state
);

  localparam logic [1:0] ST_PLAY     = 2'd0;
  localparam logic [1:0] ST_FADE_IN  = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_FADE_OUT = 2'd3;

  localparam logic [12:0] LAST_INDEX = 13'(SCREEN_PIXELS - 1);
  localparam logic [3:0]  FADE_LAST  = 4'(FADE_FRAMES - 1);
  localparam logic [7:0]  HOLD_MAX   = 8'(HOLD_FRAMES);
  localparam logic [3:0]  LEVEL_FULL = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [3:0]  fade_cnt_q, fade_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [12:0] prev_index_q;
  logic [15:0] oled_q, oled_d;
  logic        restart_q, restart_d;

  logic        frame_tick;
  logic [8:0]  r_prod;
  logic [9:0]  g_prod;
  logic [8:0]  b_prod;
  logic [15:0] scaled_death;

  // One tick per frame: only the first cycle on which the last index appears
  // counts, no matter how long the driver holds it there.
  assign frame_tick = (pixel_index == LAST_INDEX) && (prev_index_q != LAST_INDEX);

  // Each colour field is scaled by level/8; the shifted result always fits the
  // original field width since level never exceeds 8.
  assign r_prod = {4'd0, death_data[15:11]} * {5'd0, level_q};
  assign g_prod = {4'd0, death_data[10:5]}  * {6'd0, level_q};
  assign b_prod = {4'd0, death_data[4:0]}   * {5'd0, level_q};
  assign scaled_death = {5'(r_prod >> 3), 6'(g_prod >> 3), 5'(b_prod >> 3)};

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    fade_cnt_d = fade_cnt_q;
    hold_cnt_d = hold_cnt_q;
    restart_d  = 1'b0;

    case (state_q)
      ST_PLAY: begin
        if (player_dead) begin
          state_d    = ST_FADE_IN;
          level_d    = 4'd0;
          fade_cnt_d = 4'd0;
        end
      end

      ST_FADE_IN: begin
        if (frame_tick) begin
          if (fade_cnt_q == FADE_LAST) begin
            fade_cnt_d = 4'd0;
            level_d    = level_q + 4'd1;
            if (level_q == LEVEL_FULL - 4'd1) begin
              state_d    = ST_HOLD;
              hold_cnt_d = 8'd0;
            end
          end else begin
            fade_cnt_d = fade_cnt_q + 4'd1;
          end
        end
      end

      ST_HOLD: begin
        // An early press is simply dropped; only a press after the full hold
        // time starts the fade-out.
        if (btn_c && (hold_cnt_q == HOLD_MAX)) begin
          state_d    = ST_FADE_OUT;
          fade_cnt_d = 4'd0;
        end else if (frame_tick && (hold_cnt_q != HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end

      ST_FADE_OUT: begin
        if (frame_tick) begin
          if (fade_cnt_q == FADE_LAST) begin
            fade_cnt_d = 4'd0;
            level_d    = level_q - 4'd1;
            if (level_q == 4'd1) begin
              state_d   = ST_PLAY;
              restart_d = 1'b1;
            end
          end else begin
            fade_cnt_d = fade_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = ST_PLAY;
    endcase
  end

  // Pixel selection uses the current state/level; the result is registered.
  always_comb begin
    oled_d = game_data;
    case (state_q)
      ST_PLAY:  oled_d = game_data;
      ST_HOLD:  oled_d = death_data;
      default:  oled_d = scaled_death;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      level_q      <= 4'd0;
      fade_cnt_q   <= 4'd0;
      hold_cnt_q   <= 8'd0;
      prev_index_q <= 13'd0;
      oled_q       <= 16'h0000;
      restart_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      fade_cnt_q   <= fade_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      prev_index_q <= pixel_index;
      oled_q       <= oled_d;
      restart_q    <= restart_d;
    end
  end

  assign oled_data = oled_q;
  assign restart   = restart_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_death_screen_sequencer.sv
// ---------------------------------------------------------------------------
// tb_death_screen_sequencer
//
// Scoreboard bench for death_screen_sequencer (FADE_FRAMES=2, HOLD_FRAMES=3).
// Stimulus pushes {cycle, oled_data, seq_state, restart} expectations; a
// negedge monitor pops and compares them when the cycle arrives. Frames are
// driven as short index runs ending on the last pixel index, 4 clk per index.
// ---------------------------------------------------------------------------
module tb_death_screen_sequencer;

  logic        clk;
  logic        reset;
  logic [12:0] pixel_index;
  logic [15:0] game_data;
  logic [15:0] death_data;
  logic        player_dead;
  logic        btn_c;
  logic [15:0] oled_data;
  logic        restart;
  logic [1:0]  seq_state;

  death_screen_sequencer #(
    .SCREEN_PIXELS(6144),
    .FADE_FRAMES  (2),
    .HOLD_FRAMES  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_index(pixel_index),
    .game_data  (game_data),
    .death_data (death_data),
    .player_dead(player_dead),
    .btn_c      (btn_c),
    .oled_data  (oled_data),
    .restart    (restart),
    .seq_state  (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] oled;
    logic [1:0]  st;
    logic        rs;
  } exp_t;

  exp_t sb[$];
  int   cyc            = 0;
  int   tests_run      = 0;
  int   tests_failed   = 0;
  int   restart_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (restart === 1'b1) restart_pulses <= restart_pulses + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(int at, string name, logic [15:0] oled,
                           logic [1:0] st, logic rs);
    exp_t e;
    e.cyc = at; e.name = name; e.oled = oled; e.st = st; e.rs = rs;
    sb.push_back(e);
  endtask

  // Monitor: compares {oled_data, seq_state, restart} at each scheduled cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) check({e.name, "_missed_cycle"}, cyc, e.cyc);
      else check(e.name, {13'd0, oled_data, seq_state, restart},
                         {13'd0, e.oled, e.st, e.rs});
    end
  end

  // Reference scaling: each field multiplied by level and divided by 8.
  function automatic logic [15:0] scale(logic [15:0] d, int lvl);
    int r, g, b;
    r = int'(d[15:11]) * lvl / 8;
    g = int'(d[10:5])  * lvl / 8;
    b = int'(d[4:0])   * lvl / 8;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: three ordinary indices then the last index, 4 clk each.
  task automatic run_frame();
    for (int p = 0; p < 4; p++) begin
      pixel_index = 13'(6140 + p);
      step(4);
    end
  endtask

  task automatic pulse_btn();
    btn_c = 1'b1;
    step(1);
    btn_c = 1'b0;
  endtask

  initial begin
    int lvl;
    int waited;

    reset       = 1'b1;
    pixel_index = 13'd0;
    game_data   = 16'h1234;
    death_data  = 16'h0000;
    player_dead = 1'b0;
    btn_c       = 1'b0;

    // 1. Reset held two cycles, then the game pixel passes through.
    expect_at(1, "reset_c1", 16'h0000, 2'd0, 1'b0);
    expect_at(2, "reset_c2", 16'h0000, 2'd0, 1'b0);
    expect_at(3, "play_after_reset", 16'h1234, 2'd0, 1'b0);
    step(2);
    reset = 1'b0;
    step(1);

    // 2. Death pulse, fade in over 16 frames.
    death_data  = 16'hFFFF;
    player_dead = 1'b1;
    expect_at(cyc + 1, "enter_fade_in", 16'h1234, 2'd1, 1'b0);
    expect_at(cyc + 2, "fade_in_lvl0", 16'h0000, 2'd1, 1'b0);
    step(1);
    player_dead = 1'b0;
    step(1);
    for (int i = 1; i <= 16; i++) begin
      run_frame();
      lvl = i / 2;
      expect_at(cyc, $sformatf("fade_in_f%0d", i),
                (i == 2) ? 16'h18E3 : ((lvl == 8) ? 16'hFFFF : scale(16'hFFFF, lvl)),
                (lvl == 8) ? 2'd2 : 2'd1, 1'b0);
      if (i == 5) pulse_btn();
    end

    // 3. Early presses are dropped; a press after the hold (saturated) counts.
    run_frame();
    pulse_btn();
    step(1);
    expect_at(cyc, "hold_btn_early1", 16'hFFFF, 2'd2, 1'b0);
    run_frame();
    pulse_btn();
    step(1);
    expect_at(cyc, "hold_btn_early2", 16'hFFFF, 2'd2, 1'b0);
    run_frame();
    run_frame();
    btn_c = 1'b1;
    expect_at(cyc + 1, "hold_btn_accept", 16'hFFFF, 2'd3, 1'b0);
    step(1);
    btn_c = 1'b0;
    step(1);

    // 4. Fade out over 16 frames, restart pulse on the last tick.
    game_data = 16'hBEEF;
    for (int i = 1; i <= 15; i++) begin
      run_frame();
      lvl = 8 - i / 2;
      expect_at(cyc, $sformatf("fade_out_f%0d", i), scale(16'hFFFF, lvl), 2'd3, 1'b0);
      if (i == 3) pulse_btn();
    end
    for (int p = 0; p < 3; p++) begin
      pixel_index = 13'(6140 + p);
      step(4);
    end
    pixel_index = 13'd6143;
    expect_at(cyc + 1, "restart_pulse", 16'h18E3, 2'd0, 1'b1);
    expect_at(cyc + 2, "play_after_restart", 16'hBEEF, 2'd0, 1'b0);
    step(4);

    // 5. Last index held 50 cycles gives a single tick.
    player_dead = 1'b1;
    step(1);
    player_dead = 1'b0;
    pixel_index = 13'd6140;
    step(4);
    pixel_index = 13'd6143;
    step(50);
    expect_at(cyc, "held_index_one_tick", 16'h0000, 2'd1, 1'b0);
    run_frame();
    expect_at(cyc, "held_index_then_frame", 16'h18E3, 2'd1, 1'b0);

    // 6. Back to HOLD, fade out to level 5, then reset mid-fade.
    for (int i = 0; i < 14; i++) run_frame();
    expect_at(cyc, "hold_again", 16'hFFFF, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) run_frame();
    pulse_btn();
    death_data = 16'h8410;
    for (int i = 0; i < 6; i++) run_frame();
    expect_at(cyc, "fade_out_lvl5", 16'h528A, 2'd3, 1'b0);
    reset = 1'b1;
    expect_at(cyc + 1, "reset_mid_fade", 16'h0000, 2'd0, 1'b0);
    step(1);
    reset = 1'b0;
    expect_at(cyc + 1, "play_after_abort", 16'hBEEF, 2'd0, 1'b0);
    step(3);

    waited = 0;
    while (sb.size() > 0 && waited < 100) begin
      step(1);
      waited++;
    end
    if (sb.size() > 0) check("scoreboard_drain", sb.size(), 0);
    check("restart_pulse_count", restart_pulses, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
